// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 widths, register-0 index and forward-select encoding
package rv32_pkg;
  localparam int XLEN = 32;
  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_X0 = '0;
  typedef enum logic [1:0] {FWD_RF, FWD_EX, FWD_MEM, FWD_WB} fwd_sel_e;
endpackage

// File: rtl/rv32_operand_stage_if.sv
// rv32_operand_stage_if: decode, downstream-writer and execute-side signals of the operand stage
interface rv32_operand_stage_if #(parameter int CTRL_W = 32);
  import rv32_pkg::*;
  logic stall_in, flush_in, valid_in;
  logic [REG_IDX_W-1:0] rs1_in, rs2_in, rd_in;
  logic rs1_read_in, rs2_read_in, rd_write_in, mem_read_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic [XLEN-1:0] rs1_value_in, rs2_value_in;
  logic [REG_IDX_W-1:0] ex_rd_in, mem_rd_in, wb_rd_in;
  logic ex_rd_write_in, mem_rd_write_in, wb_rd_write_in, ex_mem_read_in;
  logic [XLEN-1:0] ex_result_in, mem_result_in, wb_value_in;
  logic hazard_stall_out, valid_out;
  logic [XLEN-1:0] rs1_value_out, rs2_value_out;
  logic [REG_IDX_W-1:0] rd_out;
  logic rd_write_out, mem_read_out;
  logic [CTRL_W-1:0] ctrl_out;
  modport master (
    output stall_in, flush_in, valid_in, rs1_in, rs2_in, rd_in, rs1_read_in, rs2_read_in,
           rd_write_in, mem_read_in, ctrl_in, rs1_value_in, rs2_value_in, ex_rd_in, mem_rd_in,
           wb_rd_in, ex_rd_write_in, mem_rd_write_in, wb_rd_write_in, ex_mem_read_in,
           ex_result_in, mem_result_in, wb_value_in,
    input  hazard_stall_out, valid_out, rs1_value_out, rs2_value_out, rd_out, rd_write_out,
           mem_read_out, ctrl_out
  );
  modport slave (
    input  stall_in, flush_in, valid_in, rs1_in, rs2_in, rd_in, rs1_read_in, rs2_read_in,
           rd_write_in, mem_read_in, ctrl_in, rs1_value_in, rs2_value_in, ex_rd_in, mem_rd_in,
           wb_rd_in, ex_rd_write_in, mem_rd_write_in, wb_rd_write_in, ex_mem_read_in,
           ex_result_in, mem_result_in, wb_value_in,
    output hazard_stall_out, valid_out, rs1_value_out, rs2_value_out, rd_out, rd_write_out,
           mem_read_out, ctrl_out
  );
endinterface

// File: rtl/rv32_operand_fwd.sv
// rv32_operand_fwd: one-source operand select and interlock; RV32_OPERAND_BYPASS_EN enables forwarding
module rv32_operand_fwd
  import rv32_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs,
  input  logic                 used,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic [REG_IDX_W-1:0] mem_rd,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic                 ex_we,
  input  logic                 mem_we,
  input  logic                 wb_we,
  input  logic                 ex_load,
  input  logic [XLEN-1:0]      rf_value,
  input  logic [XLEN-1:0]      ex_value,
  input  logic [XLEN-1:0]      mem_value,
  input  logic [XLEN-1:0]      wb_value,
  output logic [XLEN-1:0]      value,
  output logic                 hazard
);
`ifdef RV32_OPERAND_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic nz, ex_hit, mem_hit, wb_hit;
  fwd_sel_e sel;
  always_comb begin
    nz = rs != REG_X0;
    ex_hit = nz && ex_we && ex_rd == rs;
    mem_hit = nz && mem_we && mem_rd == rs;
    wb_hit = nz && wb_we && wb_rd == rs;
    // a load in EX has no data yet, so it drops out of the priority chain
    sel = !BYPASS ? FWD_RF : (ex_hit && !ex_load) ? FWD_EX : mem_hit ? FWD_MEM : wb_hit ? FWD_WB : FWD_RF;
    hazard = used && (BYPASS ? ex_hit && ex_load : ex_hit || mem_hit || wb_hit);
    value = !nz ? '0 : sel == FWD_EX ? ex_value : sel == FWD_MEM ? mem_value :
            sel == FWD_WB ? wb_value : rf_value;
  end
endmodule

// File: rtl/rv32_operand_stage.sv
// rv32_operand_stage: latches decode beside the register file, resolves operands, registers them into execute
// Forwarding is built in only when RV32_OPERAND_BYPASS_EN is defined; otherwise every pending writer interlocks.
module rv32_operand_stage
  import rv32_pkg::*;
#(
  parameter int CTRL_W = 32
) (
  input logic                  clk,
  input logic                  reset,
  rv32_operand_stage_if.slave  bus
);
  typedef struct packed {
    logic valid;
    logic [REG_IDX_W-1:0] rs1, rs2;
    logic rs1_read, rs2_read;
    logic [REG_IDX_W-1:0] rd;
    logic rd_write, mem_read;
    logic [CTRL_W-1:0] ctrl;
  } stage_t;
  typedef struct packed {
    logic valid;
    logic [XLEN-1:0] rs1_value, rs2_value;
    logic [REG_IDX_W-1:0] rd;
    logic rd_write, mem_read;
    logic [CTRL_W-1:0] ctrl;
  } out_t;
  stage_t s;
  out_t o;
  logic [XLEN-1:0] v1, v2;
  logic h1, h2;
  rv32_operand_fwd u_fwd1 (
    .rs(s.rs1), .used(s.rs1_read), .ex_rd(bus.ex_rd_in), .mem_rd(bus.mem_rd_in), .wb_rd(bus.wb_rd_in),
    .ex_we(bus.ex_rd_write_in), .mem_we(bus.mem_rd_write_in), .wb_we(bus.wb_rd_write_in),
    .ex_load(bus.ex_mem_read_in), .rf_value(bus.rs1_value_in), .ex_value(bus.ex_result_in),
    .mem_value(bus.mem_result_in), .wb_value(bus.wb_value_in), .value(v1), .hazard(h1)
  );
  rv32_operand_fwd u_fwd2 (
    .rs(s.rs2), .used(s.rs2_read), .ex_rd(bus.ex_rd_in), .mem_rd(bus.mem_rd_in), .wb_rd(bus.wb_rd_in),
    .ex_we(bus.ex_rd_write_in), .mem_we(bus.mem_rd_write_in), .wb_we(bus.wb_rd_write_in),
    .ex_load(bus.ex_mem_read_in), .rf_value(bus.rs2_value_in), .ex_value(bus.ex_result_in),
    .mem_value(bus.mem_result_in), .wb_value(bus.wb_value_in), .value(v2), .hazard(h2)
  );
  assign bus.hazard_stall_out = s.valid && (h1 || h2) && !bus.flush_in;
  assign bus.valid_out = o.valid;
  assign bus.rs1_value_out = o.rs1_value;
  assign bus.rs2_value_out = o.rs2_value;
  assign bus.rd_out = o.rd;
  assign bus.rd_write_out = o.rd_write;
  assign bus.mem_read_out = o.mem_read;
  assign bus.ctrl_out = o.ctrl;
  always_ff @(posedge clk) begin
    if (reset) begin
      s <= '0;
      o <= '0;
    end else if (bus.flush_in) begin
      s.valid <= 1'b0;
      o.valid <= 1'b0;
    end else if (!bus.stall_in) begin
      o <= bus.hazard_stall_out ? '0 : out_t'{valid: s.valid, rs1_value: v1, rs2_value: v2, rd: s.rd,
                                              rd_write: s.rd_write, mem_read: s.mem_read, ctrl: s.ctrl};
      if (!bus.hazard_stall_out)
        s <= stage_t'{valid: bus.valid_in, rs1: bus.rs1_in, rs2: bus.rs2_in, rs1_read: bus.rs1_read_in,
                      rs2_read: bus.rs2_read_in, rd: bus.rd_in, rd_write: bus.rd_write_in,
                      mem_read: bus.mem_read_in, ctrl: bus.ctrl_in};
    end
  end
endmodule

// File: tb/tb_rv32_operand_stage.sv
// tb_rv32_operand_stage: directed scenarios plus random traffic checked against an instruction-level model
module tb_rv32_operand_stage;
  import rv32_pkg::*;
  localparam int CTRL_W = 32;
`ifdef RV32_OPERAND_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  rv32_operand_stage_if #(.CTRL_W(CTRL_W)) bus ();
  rv32_operand_stage #(.CTRL_W(CTRL_W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  int checks = 0, errors = 0;
  // instruction currently held by the stage, and what execute should see next
  bit m_valid, m_u1, m_u2, m_rdw, m_mr;
  logic [4:0] m_rs1, m_rs2, m_rd;
  logic [31:0] m_ctrl;
  bit e_valid, e_rdw, e_mr;
  logic [31:0] e_v1, e_v2, e_ctrl;
  logic [4:0] e_rd;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] resolve(logic [4:0] rs, logic [31:0] rf);
    if (rs == 0) return 32'h0;
    if (BYPASS) begin
      if (bus.ex_rd_write_in && bus.ex_rd_in == rs && !bus.ex_mem_read_in) return bus.ex_result_in;
      if (bus.mem_rd_write_in && bus.mem_rd_in == rs) return bus.mem_result_in;
      if (bus.wb_rd_write_in && bus.wb_rd_in == rs) return bus.wb_value_in;
    end
    return rf;
  endfunction
  function automatic bit blocks(logic [4:0] rs, bit used);
    bit ex_m, mem_m, wb_m;
    if (!used || rs == 0) return 1'b0;
    ex_m = bus.ex_rd_write_in && bus.ex_rd_in == rs;
    mem_m = bus.mem_rd_write_in && bus.mem_rd_in == rs;
    wb_m = bus.wb_rd_write_in && bus.wb_rd_in == rs;
    return BYPASS ? (ex_m && bus.ex_mem_read_in) : (ex_m || mem_m || wb_m);
  endfunction
  task automatic clear_inputs();
    reset = 1'b0;
    {bus.stall_in, bus.flush_in, bus.valid_in, bus.rs1_read_in, bus.rs2_read_in, bus.rd_write_in,
     bus.mem_read_in, bus.ex_rd_write_in, bus.mem_rd_write_in, bus.wb_rd_write_in, bus.ex_mem_read_in} = '0;
    {bus.rs1_in, bus.rs2_in, bus.rd_in, bus.ex_rd_in, bus.mem_rd_in, bus.wb_rd_in} = '0;
    {bus.ctrl_in, bus.rs1_value_in, bus.rs2_value_in, bus.ex_result_in, bus.mem_result_in, bus.wb_value_in} = '0;
  endtask
  task automatic rand_inputs();
    reset = $urandom_range(0, 49) == 0;
    bus.stall_in = $urandom_range(0, 9) == 0;
    bus.flush_in = $urandom_range(0, 19) == 0;
    bus.valid_in = $urandom_range(0, 3) != 0;
    bus.rs1_in = 5'($urandom_range(0, 3));
    bus.rs2_in = 5'($urandom_range(0, 3));
    bus.rd_in = 5'($urandom_range(0, 31));
    {bus.rs1_read_in, bus.rs2_read_in, bus.rd_write_in, bus.mem_read_in} = 4'($urandom);
    bus.ctrl_in = $urandom;
    bus.rs1_value_in = $urandom;
    bus.rs2_value_in = $urandom;
    bus.ex_rd_in = 5'($urandom_range(0, 3));
    bus.mem_rd_in = 5'($urandom_range(0, 3));
    bus.wb_rd_in = 5'($urandom_range(0, 3));
    {bus.ex_rd_write_in, bus.mem_rd_write_in, bus.wb_rd_write_in, bus.ex_mem_read_in} = 4'($urandom);
    bus.ex_result_in = $urandom;
    bus.mem_result_in = $urandom;
    bus.wb_value_in = $urandom;
  endtask
  // called just after a negedge with inputs applied; returns just after the next negedge
  task automatic step();
    bit h;
    #1;
    h = m_valid && (blocks(m_rs1, m_u1) || blocks(m_rs2, m_u2)) && !bus.flush_in;
    check("hazard_stall_out", bus.hazard_stall_out, h);
    if (reset) begin
      {m_valid, m_u1, m_u2, m_rdw, m_mr, m_rs1, m_rs2, m_rd, m_ctrl} = '0;
      {e_valid, e_rdw, e_mr, e_v1, e_v2, e_ctrl, e_rd} = '0;
    end else if (bus.flush_in) begin
      m_valid = 1'b0;
      e_valid = 1'b0;
    end else if (!bus.stall_in) begin
      if (h) {e_valid, e_rdw, e_mr, e_v1, e_v2, e_ctrl, e_rd} = '0;
      else begin
        e_valid = m_valid; e_v1 = resolve(m_rs1, bus.rs1_value_in); e_v2 = resolve(m_rs2, bus.rs2_value_in);
        e_rd = m_rd; e_rdw = m_rdw; e_mr = m_mr; e_ctrl = m_ctrl;
        m_valid = bus.valid_in; m_rs1 = bus.rs1_in; m_rs2 = bus.rs2_in; m_u1 = bus.rs1_read_in;
        m_u2 = bus.rs2_read_in; m_rd = bus.rd_in; m_rdw = bus.rd_write_in; m_mr = bus.mem_read_in;
        m_ctrl = bus.ctrl_in;
      end
    end
    @(posedge clk);
    #1;
    check("valid_out", bus.valid_out, e_valid);
    check("rs1_value_out", bus.rs1_value_out, e_v1);
    check("rs2_value_out", bus.rs2_value_out, e_v2);
    check("rd_fields", {bus.rd_out, bus.rd_write_out, bus.mem_read_out}, {e_rd, e_rdw, e_mr});
    check("ctrl_out", bus.ctrl_out, e_ctrl);
    @(negedge clk);
  endtask
  task automatic consumer(logic [4:0] r1, logic [4:0] r2);
    clear_inputs();
    bus.valid_in = 1'b1;
    bus.rs1_in = r1; bus.rs2_in = r2; bus.rs1_read_in = 1'b1; bus.rs2_read_in = 1'b1;
    bus.rd_in = 5'd6; bus.rd_write_in = 1'b1; bus.ctrl_in = 32'hC0DE_0000 | 32'(r1);
    step();
  endtask
  initial begin
    clear_inputs();
    {m_valid, m_u1, m_u2, m_rdw, m_mr, m_rs1, m_rs2, m_rd, m_ctrl} = '0;
    {e_valid, e_rdw, e_mr, e_v1, e_v2, e_ctrl, e_rd} = '0;
    @(negedge clk);
    reset = 1'b1;
    bus.valid_in = 1'b1;
    step();
    step();
    check("reset_valid_out", bus.valid_out, 1'b0);
    check("reset_hazard", bus.hazard_stall_out, 1'b0);
    consumer(5'd5, 5'd5);
`ifdef RV32_OPERAND_BYPASS_EN
    clear_inputs();
    bus.ex_rd_in = 5'd5; bus.ex_rd_write_in = 1'b1; bus.ex_result_in = 32'h11;
    step();
    check("ex_fwd_rs1", bus.rs1_value_out, 32'h11);
    check("ex_fwd_rs2", bus.rs2_value_out, 32'h11);
    consumer(5'd5, 5'd0);
    clear_inputs();
    bus.ex_rd_in = 5'd5; bus.ex_rd_write_in = 1'b1; bus.ex_result_in = 32'hAA;
    bus.mem_rd_in = 5'd5; bus.mem_rd_write_in = 1'b1; bus.mem_result_in = 32'hBB;
    bus.rs2_value_in = 32'h1234;
    step();
    check("ex_over_mem", bus.rs1_value_out, 32'hAA);
    check("x0_operand", bus.rs2_value_out, 32'h0);
    consumer(5'd7, 5'd0);
    clear_inputs();
    bus.ex_rd_in = 5'd7; bus.ex_rd_write_in = 1'b1; bus.ex_mem_read_in = 1'b1;
    step();
    check("load_use_bubble", bus.valid_out, 1'b0);
    clear_inputs();
    bus.mem_rd_in = 5'd7; bus.mem_rd_write_in = 1'b1; bus.mem_result_in = 32'hDEADBEEF;
    step();
    check("load_use_fwd", bus.rs1_value_out, 32'hDEADBEEF);
    check("load_use_valid", bus.valid_out, 1'b1);
`else
    consumer(5'd9, 5'd0);
    clear_inputs();
    bus.wb_rd_in = 5'd9; bus.wb_rd_write_in = 1'b1; bus.wb_value_in = 32'h77;
    step();
    check("wb_stall_bubble", bus.valid_out, 1'b0);
    clear_inputs();
    bus.rs1_value_in = 32'h99;
    step();
    check("rf_after_stall", bus.rs1_value_out, 32'h99);
    check("rf_after_stall_valid", bus.valid_out, 1'b1);
`endif
    consumer(5'd9, 5'd9);
    clear_inputs();
    bus.ex_rd_in = 5'd9; bus.ex_rd_write_in = 1'b1; bus.ex_mem_read_in = 1'b1; bus.flush_in = 1'b1;
    step();
    check("flush_kills_out", bus.valid_out, 1'b0);
    bus.flush_in = 1'b0;
    step();
    check("flush_kills_stage", bus.valid_out, 1'b0);
    consumer(5'd3, 5'd2);
    clear_inputs();
    bus.stall_in = 1'b1; bus.valid_in = 1'b1; bus.rs1_in = 5'd1; bus.ctrl_in = 32'hFFFF;
    for (int i = 0; i < 3; i++) begin
      bus.rs1_value_in = $urandom;
      step();
    end
    clear_inputs();
    step();
    step();
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
